multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/mc_ctrl_pkg.sv | 79 +++++++
 rtl/mc_ctrl_if.sv | 37 +++
 rtl/mc_op_decode.sv | 33 +++
 rtl/multicycle_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multi-cycle processor controller:
//   - state encoding (enum plus the numeric values shown on the debug port)
//   - instruction opcodes recognised by the controller
//   - datapath select / ALU-class encodings
//   - instruction-class one-hot bit positions produced by mc_op_decode
//   - sel_safe(): maps the never-valid select code 2'b11 back to 2'b00
// Optional feature macro: MC_CTRL_JAL_EN (JAL support, see mc_op_decode and
// multicycle_ctrl).
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

  // Controller states; the numeric value is what appears on the state port.
  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECR    = 4'd6,
    ST_EXECI    = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_JAL      = 4'd9,
    ST_BEQ      = 4'd10
  } state_e;

  // Opcodes
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  // ALU operand A select
  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  // Result select
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU decoder class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Instruction-class one-hot bit positions
  localparam int CLS_LOAD  = 0;
  localparam int CLS_STORE = 1;
  localparam int CLS_RTYPE = 2;
  localparam int CLS_ITYPE = 3;
  localparam int CLS_JAL   = 4;
  localparam int CLS_BEQ   = 5;
  localparam int CLS_W     = 6;

  typedef logic [CLS_W-1:0] cls_t;

  // 2'b11 is not a legal select on any mux; never let it reach the datapath.
  function automatic logic [1:0] sel_safe(input logic [1:0] sel);
    logic [1:0] res;
    if (sel == 2'b11) begin
      res = 2'b00;
    end else begin
      res = sel;
    end
    return res;
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// -----------------------------------------------------------------------------
// mc_ctrl_if
// Bundle between the multi-cycle controller and its datapath.
//   Datapath -> controller : op[6:0], zero, mem_ready
//   Controller -> datapath : pc_write, ir_write, reg_write, mem_write, adr_src,
//                            result_src[1:0], alu_src_a[1:0], alu_src_b[1:0],
//                            alu_op[1:0], illegal, state[3:0] (debug)
// Modports: master = datapath side, slave = controller side.
// -----------------------------------------------------------------------------
interface mc_ctrl_if;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_write;
  logic       adr_src;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       illegal;
  logic [3:0] state;

  modport master (
    output op, zero, mem_ready,
    input  pc_write, ir_write, reg_write, mem_write, adr_src,
    input  result_src, alu_src_a, alu_src_b, alu_op, illegal, state
  );

  modport slave (
    input  op, zero, mem_ready,
    output pc_write, ir_write, reg_write, mem_write, adr_src,
    output result_src, alu_src_a, alu_src_b, alu_op, illegal, state
  );
endinterface

// File: rtl/mc_op_decode.sv
// -----------------------------------------------------------------------------
// mc_op_decode
// Combinational opcode classifier: op -> one-hot instruction class.
// An all-zero class vector means the opcode is unsupported.
//   i_op  [6:0]      opcode field
//   o_cls [CLS_W-1:0] one-hot class (bit positions from mc_ctrl_pkg)
// Optional feature macro: MC_CTRL_JAL_EN -- when undefined, OP_JAL decodes
// as unsupported.
// -----------------------------------------------------------------------------
module mc_op_decode
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] i_op,
  output cls_t       o_cls
);

  // Opcode to one-hot class lookup
  always_comb begin
    o_cls = {CLS_W{1'b0}};
    case (i_op)
      OP_LOAD:  o_cls[CLS_LOAD]  = 1'b1;
      OP_STORE: o_cls[CLS_STORE] = 1'b1;
      OP_RTYPE: o_cls[CLS_RTYPE] = 1'b1;
      OP_ITYPE: o_cls[CLS_ITYPE] = 1'b1;
`ifdef MC_CTRL_JAL_EN
      OP_JAL:   o_cls[CLS_JAL]   = 1'b1;
`endif
      OP_BEQ:   o_cls[CLS_BEQ]   = 1'b1;
      default:  o_cls = {CLS_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Moore-style main controller of a multi-cycle RISC-V-like processor.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; forces FETCH and, while high, holds all
//           write enables at 0 and shows the FETCH selects/state
//   bus   : mc_ctrl_if.slave (op/zero/mem_ready in, enables/selects/state out)
// Outputs are decoded from the state register; the only input terms are
// mem_ready (FETCH handshake), zero (branch), op (illegal in DECODE) and reset.
// Optional feature macro: MC_CTRL_JAL_EN -- enables the JAL state (9); when
// undefined, encoding 9 behaves like any other unused encoding.
// -----------------------------------------------------------------------------
module multicycle_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  mc_ctrl_if.slave  bus
);

  localparam logic [3:0] S_FETCH    = ST_FETCH;
  localparam logic [3:0] S_DECODE   = ST_DECODE;
  localparam logic [3:0] S_MEMADR   = ST_MEMADR;
  localparam logic [3:0] S_MEMREAD  = ST_MEMREAD;
  localparam logic [3:0] S_MEMWB    = ST_MEMWB;
  localparam logic [3:0] S_MEMWRITE = ST_MEMWRITE;
  localparam logic [3:0] S_EXECR    = ST_EXECR;
  localparam logic [3:0] S_EXECI    = ST_EXECI;
  localparam logic [3:0] S_ALUWB    = ST_ALUWB;
  localparam logic [3:0] S_JAL      = ST_JAL;
  localparam logic [3:0] S_BEQ      = ST_BEQ;

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  cls_t       w_cls;

  logic       w_pc_update;
  logic       w_branch;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_mem_write;
  logic       w_adr_src;
  logic       w_illegal;
  logic [1:0] w_src_a;
  logic [1:0] w_src_b;
  logic [1:0] w_alu_op;
  logic [1:0] w_result_src;
  logic [3:0] w_state_out;

  mc_op_decode u_op_decode (
    .i_op  (bus.op),
    .o_cls (w_cls)
  );

  // Next-state selection
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH: begin
        if (bus.mem_ready) begin
          w_next_state = S_DECODE;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_DECODE: begin
        if (w_cls[CLS_LOAD] | w_cls[CLS_STORE]) begin
          w_next_state = S_MEMADR;
        end else if (w_cls[CLS_RTYPE]) begin
          w_next_state = S_EXECR;
        end else if (w_cls[CLS_ITYPE]) begin
          w_next_state = S_EXECI;
        end else if (w_cls[CLS_JAL]) begin
          w_next_state = S_JAL;
        end else if (w_cls[CLS_BEQ]) begin
          w_next_state = S_BEQ;
        end else begin
          // unsupported opcode: abandon the instruction
          w_next_state = S_FETCH;
        end
      end
      S_MEMADR: begin
        if (w_cls[CLS_LOAD]) begin
          w_next_state = S_MEMREAD;
        end else begin
          w_next_state = S_MEMWRITE;
        end
      end
      S_MEMREAD: begin
        if (bus.mem_ready) begin
          w_next_state = S_MEMWB;
        end else begin
          w_next_state = S_MEMREAD;
        end
      end
      S_MEMWB:  w_next_state = S_FETCH;
      S_MEMWRITE: begin
        if (bus.mem_ready) begin
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_MEMWRITE;
        end
      end
      S_EXECR:  w_next_state = S_ALUWB;
      S_EXECI:  w_next_state = S_ALUWB;
      S_ALUWB:  w_next_state = S_FETCH;
`ifdef MC_CTRL_JAL_EN
      S_JAL:    w_next_state = S_ALUWB;
`endif
      S_BEQ:    w_next_state = S_FETCH;
      default:  w_next_state = S_FETCH;
    endcase
  end

  // Output decode; reset overrides the state so FETCH values show immediately
  always_comb begin
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_write  = 1'b0;
    w_adr_src    = 1'b0;
    w_illegal    = 1'b0;
    w_src_a      = SRC_A_PC;
    w_src_b      = SRC_B_RS2;
    w_alu_op     = ALUOP_ADD;
    w_result_src = RES_ALUOUT;
    w_state_out  = r_state;
    if (reset) begin
      w_src_b      = SRC_B_FOUR;
      w_result_src = RES_ALURESULT;
      w_state_out  = S_FETCH;
    end else begin
      case (r_state)
        S_FETCH: begin
          w_src_b      = SRC_B_FOUR;
          w_result_src = RES_ALURESULT;
          // instruction latch and PC+4 happen only on the completing cycle
          if (bus.mem_ready) begin
            w_ir_write  = 1'b1;
            w_pc_update = 1'b1;
          end else begin
            w_ir_write  = 1'b0;
            w_pc_update = 1'b0;
          end
        end
        S_DECODE: begin
          w_src_a   = SRC_A_OLDPC;
          w_src_b   = SRC_B_IMM;
          w_illegal = (w_cls == {CLS_W{1'b0}});
        end
        S_MEMADR: begin
          w_src_a = SRC_A_RS1;
          w_src_b = SRC_B_IMM;
        end
        S_MEMREAD: w_adr_src = 1'b1;
        S_MEMWB: begin
          w_result_src = RES_READDATA;
          w_reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          w_adr_src   = 1'b1;
          w_mem_write = 1'b1;
        end
        S_EXECR: begin
          w_src_a  = SRC_A_RS1;
          w_src_b  = SRC_B_RS2;
          w_alu_op = ALUOP_FUNCT;
        end
        S_EXECI: begin
          w_src_a  = SRC_A_RS1;
          w_src_b  = SRC_B_IMM;
          w_alu_op = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          w_result_src = RES_ALUOUT;
          w_reg_write  = 1'b1;
        end
`ifdef MC_CTRL_JAL_EN
        S_JAL: begin
          w_src_a     = SRC_A_OLDPC;
          w_src_b     = SRC_B_FOUR;
          w_pc_update = 1'b1;
        end
`endif
        S_BEQ: begin
          w_src_a  = SRC_A_RS1;
          w_src_b  = SRC_B_RS2;
          w_alu_op = ALUOP_SUB;
          w_branch = 1'b1;
        end
        default: begin
          // unused encodings: everything stays at the idle defaults
          w_illegal = 1'b0;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  assign bus.pc_write   = w_pc_update | (w_branch & bus.zero);
  assign bus.ir_write   = w_ir_write;
  assign bus.reg_write  = w_reg_write;
  assign bus.mem_write  = w_mem_write;
  assign bus.adr_src    = w_adr_src;
  assign bus.illegal    = w_illegal;
  assign bus.alu_src_a  = sel_safe(w_src_a);
  assign bus.alu_src_b  = sel_safe(w_src_b);
  assign bus.alu_op     = sel_safe(w_alu_op);
  assign bus.result_src = sel_safe(w_result_src);
  assign bus.state      = w_state_out;

endmodule
